receive_os: RTL and testbench
=============================

# receive_os

Parametrised oversampling UART receiver, successor to the fixed 8N1 receiver in the serial path. It samples `rxd` at a configurable oversample rate with mid-bit sampling and start-bit glitch rejection. Data width, parity and stop bits are configurable. Frames land in a show-ahead FIFO with per-word framing/parity flags and a sticky overrun flag. It sits between the baud generator (supplies `sample_tick`) and the bus-side reader (`receive_read_en` / `receive_read_line`).

## Interface
- `DATA_BITS`, 8: data bits per frame, legal 5..9.
- `OVERSAMPLE`, 16: `sample_tick` pulses per bit period; even, ≥ 8.
- `PARITY`, 0: 0 = none, 1 = even, 2 = odd.
- `STOP_BITS`, 1: 1 or 2.
- `FIFO_DEPTH`, 4: power of 2, ≥ 2.
- `clk`  in  1  clock; one clock for the whole block.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `rxd`  in  1  serial line, asynchronous, idles high.
- `sample_tick`  in  1  one-`clk` pulse at OVERSAMPLE × baud.
- `receive_read_en`  in  1  pop head word when `rda` = 1.
- `clear_errors`  in  1  clears `overrun`.
- `rda`  out  1  FIFO not empty.
- `receive_read_line`  out  DATA_BITS  head word, LSB = first received bit.
- `framing_err`  out  1  head word had a 0 in a stop bit.
- `parity_err`  out  1  head word failed parity; always 0 when PARITY = 0.
- `overrun`  out  1  sticky; a completed frame was dropped because the FIFO was full.
- `fifo_count`  out  $clog2(FIFO_DEPTH)+1  occupancy.

## Operation
- `rxd` is double-flopped; both flops preset to 1 on reset. All sampling uses the second flop (`rxs`).
- FSM states: IDLE, START, DATA, PAR, STOP. A tick counter (OVERSAMPLE range) and a bit counter drive the FSM.
- The counter only advances on `sample_tick`; non-tick cycles hold all state.
- IDLE: on a tick with `rxs` = 0, go to START with counter = 0.
- START: on the tick where counter reaches OVERSAMPLE/2−1, sample `rxs`.
  - 1: glitch; return to IDLE. Nothing is pushed and no flag is set.
  - 0: counter = 0, go to DATA. Every later sample is taken at counter = OVERSAMPLE−1, which is mid-bit.
- DATA: shift `DATA_BITS` samples in LSB-first. Then go to PAR if PARITY ≠ 0, otherwise go to STOP.
- PAR: compare the sampled bit against the XOR of the data bits (even) or its inverse (odd). A mismatch sets the word's parity flag.
- STOP: sample `STOP_BITS` bits. Any 0 sets the word's framing flag.
  - After the last stop sample: push {parity flag, framing flag, data} and return to IDLE immediately, with no wait for a full stop period.
  - Frames with errors are still pushed.
- FIFO is show-ahead: the outputs always show the head entry. `receive_read_line`/flags are don't-care when `rda` = 0 (implementation drives 0).
- Pop on `receive_read_en` & `rda`. `receive_read_en` with an empty FIFO is ignored.
- Push while full and no pop in the same cycle: the word is dropped, FIFO contents are unchanged, and `overrun` is set.
- Push and pop in the same cycle while full: both happen, count unchanged, no overrun. Push and pop while empty: push only.
- `overrun` stays set until `clear_errors` = 1. If `clear_errors` and a new overrun occur in the same cycle, `overrun` stays set.

## Timing
- Reset values: `rda` = 0, `receive_read_line` = 0, `framing_err` = 0, `parity_err` = 0, `overrun` = 0, `fifo_count` = 0, FSM = IDLE, sync flops = 1.
- Reset mid-frame aborts the frame and empties the FIFO. The first frame after reset needs a new falling edge.
- `rxd` to `rxs`: 2 `clk` cycles.
- Push happens at the `clk` edge that processes the final stop-sample tick. `rda`, `fifo_count` and the head outputs update on that same edge, so they are registered and valid the next cycle.
- Pop: `fifo_count` decrements on the edge where `receive_read_en` is sampled. The next head word appears on the outputs in the following cycle.
- Start detect can re-arm on the first tick after the push. Back-to-back frames with zero idle time must be received.

## Structure
- Package `uart_pkg`:
  - `rx_state_t` enum for IDLE/START/DATA/PAR/STOP.
  - `parity_t` localparams PAR_NONE/PAR_EVEN/PAR_ODD.
  - Shared with the planned parametrised transmitter.
- Sub-module `rx_fifo`: synchronous, show-ahead, parameters WIDTH = DATA_BITS+2 and DEPTH. Ports are push/pop/full/empty/count. Full vs empty is resolved with count or an extra pointer bit, with wrap at DEPTH.
- Parameter legality is checked by elaboration-time assertions.

## Test plan
- 8N1, OVERSAMPLE = 16: send 0xA5 → `rda` = 1, `receive_read_line` = 0xA5, both error flags 0. Pulse `receive_read_en` → `rda` = 0 the next cycle.
- PARITY = 1 (even), 0x03 sent with parity bit 1 → `parity_err` = 1 with data 0x03. Same frame with parity bit 0 → `parity_err` = 0.
- Send 0x3C with stop bit forced 0 → `framing_err` = 1, data 0x3C. Then send 0x55 back-to-back → received clean.
- `rxd` low for 4 ticks then high → no push, `rda` stays 0. A following 0x81 frame is received correctly.
- FIFO_DEPTH = 4, send 0x01..0x05 without reading → `overrun` = 1, reads return 0x01..0x04. Assert `clear_errors` → `overrun` = 0.
- DATA_BITS = 7, odd parity, STOP_BITS = 2: send 0x7F; assert `rst_n` low mid-DATA on the next frame → all outputs at reset values, next frame 0x2A received cleanly.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg
//   Types and helpers shared by the oversampling receiver (receive_os) and
//   the parametrised transmitter that will reuse the same frame format.
//   Contents:
//     rx_state_t    receiver FSM state encoding
//     parity_t      parity mode with PAR_NONE / PAR_EVEN / PAR_ODD
//     parity_bit()  expected parity bit for a data word under a parity mode
package uart_pkg;

  // Receiver FSM states
  typedef enum logic [2:0] {
    RX_IDLE  = 3'd0,
    RX_START = 3'd1,
    RX_DATA  = 3'd2,
    RX_PAR   = 3'd3,
    RX_STOP  = 3'd4
  } rx_state_t;

  // Parity mode encoding; matches the integer PARITY parameter values
  typedef logic [1:0] parity_t;
  localparam parity_t PAR_NONE = 2'd0;
  localparam parity_t PAR_EVEN = 2'd1;
  localparam parity_t PAR_ODD  = 2'd2;

  // Widest data word any UART in this family carries
  localparam int MAX_DATA_BITS = 9;

  // Expected parity bit for a data word. Narrower words are zero-extended,
  // which leaves the XOR reduction unchanged.
  function automatic logic parity_bit(input logic [MAX_DATA_BITS-1:0] data,
                                      input parity_t mode);
    logic p;
    p = ^data;
    if (mode == PAR_ODD) begin
      parity_bit = ~p;
    end else begin
      parity_bit = p;
    end
  endfunction

endpackage

// File: rtl/rx_fifo.sv
// rx_fifo
//   Synchronous show-ahead FIFO. The head entry is held in a register, so
//   the head output, count, full and empty all change only on a clock edge.
//   When the FIFO is empty the head output reads as zero.
//   Ports:
//     clk, rst_n     clock, asynchronous active-low reset
//     push/push_data write one word (ignored when full unless popping too)
//     pop            remove the head word (ignored when empty)
//     head           current head word (zero when empty)
//     full/empty     occupancy flags
//     count          occupancy, 0..DEPTH
module rx_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  import uart_pkg::*;

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0] ONE_C   = (PTR_W+1)'(1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic [WIDTH-1:0] r_head;

  logic             w_full;
  logic             w_empty;
  logic             w_do_push;
  logic             w_do_pop;
  logic [PTR_W-1:0] w_rd_ptr_inc;
  logic [PTR_W:0]   w_count_nxt;
  logic [WIDTH-1:0] w_head_nxt;

  assign w_full       = (r_count == DEPTH_C);
  assign w_empty      = (r_count == {(PTR_W+1){1'b0}});
  assign w_do_pop     = pop & ~w_empty;
  // A pop frees the slot, so a push into a full FIFO is accepted alongside it
  assign w_do_push    = push & (~w_full | w_do_pop);
  assign w_rd_ptr_inc = r_rd_ptr + PTR_W'(1);

  // Next occupancy and next head word
  always_comb begin
    w_count_nxt = r_count;
    w_head_nxt  = r_head;
    case ({w_do_push, w_do_pop})
      2'b10:   w_count_nxt = r_count + ONE_C;
      2'b01:   w_count_nxt = r_count - ONE_C;
      default: w_count_nxt = r_count;
    endcase
    if (w_do_pop) begin
      // Last word leaving: the new head is the word arriving, if any
      if (r_count == ONE_C) begin
        if (w_do_push) begin
          w_head_nxt = push_data;
        end else begin
          w_head_nxt = {WIDTH{1'b0}};
        end
      end else begin
        w_head_nxt = r_mem[w_rd_ptr_inc];
      end
    end else if (w_empty) begin
      if (w_do_push) begin
        w_head_nxt = push_data;
      end else begin
        w_head_nxt = {WIDTH{1'b0}};
      end
    end else begin
      w_head_nxt = r_head;
    end
  end

  // Pointers, occupancy and head register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= {PTR_W{1'b0}};
      r_rd_ptr <= {PTR_W{1'b0}};
      r_count  <= {(PTR_W+1){1'b0}};
      r_head   <= {WIDTH{1'b0}};
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= w_rd_ptr_inc;
      end
      r_count <= w_count_nxt;
      r_head  <= w_head_nxt;
    end
  end

  // Storage array; contents are only read while occupied, so no reset needed
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= push_data;
    end
  end

  assign head  = r_head;
  assign full  = w_full;
  assign empty = w_empty;
  assign count = r_count;

endmodule

// File: rtl/receive_os.sv
// receive_os
//   Oversampling UART receiver. rxd is synchronised, the start bit is
//   confirmed at its midpoint (a high sample there is a glitch and is
//   dropped), then every further bit is sampled one bit period later, i.e.
//   mid-bit. Completed frames, including ones with errors, are pushed into a
//   show-ahead FIFO together with their parity and framing flags.
//   Ports:
//     clk, rst_n          clock, asynchronous active-low reset
//     rxd                 asynchronous serial input, idles high
//     sample_tick         one-clk pulse at OVERSAMPLE x baud
//     receive_read_en     pop the head word when rda is set
//     clear_errors        clear the sticky overrun flag
//     rda                 FIFO not empty
//     receive_read_line   head data word, LSB = first received bit
//     framing_err         head word saw a 0 in a stop bit
//     parity_err          head word failed parity
//     overrun             sticky; a completed frame was dropped (FIFO full)
//     fifo_count          FIFO occupancy
module receive_os #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          rxd,
  input  logic                          sample_tick,
  input  logic                          receive_read_en,
  input  logic                          clear_errors,
  output logic                          rda,
  output logic [DATA_BITS-1:0]          receive_read_line,
  output logic                          framing_err,
  output logic                          parity_err,
  output logic                          overrun,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
  import uart_pkg::*;

  localparam int      CNT_W   = $clog2(OVERSAMPLE);
  localparam int      BIT_W   = 4;
  localparam int      WORD_W  = DATA_BITS + 2;
  localparam parity_t P_MODE  = parity_t'(PARITY);
  localparam bit      HAS_PAR = (PARITY != 0);

  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(OVERSAMPLE/2 - 1);
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);

  // Parameter legality, checked at elaboration
  if ((DATA_BITS < 5) || (DATA_BITS > 9)) begin : g_bad_data_bits
    $error("receive_os: DATA_BITS must be in 5..9");
  end
  if ((OVERSAMPLE < 8) || ((OVERSAMPLE % 2) != 0)) begin : g_bad_oversample
    $error("receive_os: OVERSAMPLE must be even and at least 8");
  end
  if ((PARITY < 0) || (PARITY > 2)) begin : g_bad_parity
    $error("receive_os: PARITY must be 0, 1 or 2");
  end
  if ((STOP_BITS < 1) || (STOP_BITS > 2)) begin : g_bad_stop_bits
    $error("receive_os: STOP_BITS must be 1 or 2");
  end
  if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("receive_os: FIFO_DEPTH must be a power of 2, at least 2");
  end

  logic                 r_rxd_meta;
  logic                 r_rxs;
  rx_state_t            r_state;
  logic [CNT_W-1:0]     r_tick_cnt;
  logic [BIT_W-1:0]     r_bit_cnt;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_par_err;
  logic                 r_frm_err;
  logic                 r_overrun;

  rx_state_t            w_state_nxt;
  logic [CNT_W-1:0]     w_tick_cnt_nxt;
  logic [BIT_W-1:0]     w_bit_cnt_nxt;
  logic [DATA_BITS-1:0] w_shift_nxt;
  logic                 w_par_err_nxt;
  logic                 w_frm_err_nxt;
  logic                 w_push;
  logic [WORD_W-1:0]    w_push_word;
  logic [WORD_W-1:0]    w_head;
  logic                 w_full;
  logic                 w_empty;
  logic                 w_pop;
  logic                 w_drop;

  // Two-flop synchroniser on the serial line, preset to the idle level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rxd_meta <= 1'b1;
      r_rxs      <= 1'b1;
    end else begin
      r_rxd_meta <= rxd;
      r_rxs      <= r_rxd_meta;
    end
  end

  // Frame FSM next-state and datapath; everything holds between ticks
  always_comb begin
    w_state_nxt    = r_state;
    w_tick_cnt_nxt = r_tick_cnt;
    w_bit_cnt_nxt  = r_bit_cnt;
    w_shift_nxt    = r_shift;
    w_par_err_nxt  = r_par_err;
    w_frm_err_nxt  = r_frm_err;
    w_push         = 1'b0;
    if (sample_tick) begin
      case (r_state)
        RX_IDLE: begin
          if (!r_rxs) begin
            w_state_nxt    = RX_START;
            w_tick_cnt_nxt = {CNT_W{1'b0}};
            w_bit_cnt_nxt  = {BIT_W{1'b0}};
            w_par_err_nxt  = 1'b0;
            w_frm_err_nxt  = 1'b0;
          end else begin
            w_state_nxt = RX_IDLE;
          end
        end
        RX_START: begin
          // Half a bit after the falling edge: still low means a real start
          if (r_tick_cnt == HALF_LAST) begin
            w_tick_cnt_nxt = {CNT_W{1'b0}};
            if (r_rxs) begin
              w_state_nxt = RX_IDLE;
            end else begin
              w_state_nxt = RX_DATA;
            end
          end else begin
            w_tick_cnt_nxt = r_tick_cnt + CNT_W'(1);
          end
        end
        RX_DATA: begin
          if (r_tick_cnt == FULL_LAST) begin
            w_tick_cnt_nxt = {CNT_W{1'b0}};
            // Shift in from the top so the first bit ends up in the LSB
            w_shift_nxt    = {r_rxs, r_shift[DATA_BITS-1:1]};
            if (r_bit_cnt == DATA_LAST) begin
              w_bit_cnt_nxt = {BIT_W{1'b0}};
              if (HAS_PAR) begin
                w_state_nxt = RX_PAR;
              end else begin
                w_state_nxt = RX_STOP;
              end
            end else begin
              w_bit_cnt_nxt = r_bit_cnt + BIT_W'(1);
            end
          end else begin
            w_tick_cnt_nxt = r_tick_cnt + CNT_W'(1);
          end
        end
        RX_PAR: begin
          if (r_tick_cnt == FULL_LAST) begin
            w_tick_cnt_nxt = {CNT_W{1'b0}};
            w_par_err_nxt  = (r_rxs != parity_bit(MAX_DATA_BITS'(r_shift), P_MODE));
            w_state_nxt    = RX_STOP;
          end else begin
            w_tick_cnt_nxt = r_tick_cnt + CNT_W'(1);
          end
        end
        RX_STOP: begin
          if (r_tick_cnt == FULL_LAST) begin
            w_tick_cnt_nxt = {CNT_W{1'b0}};
            w_frm_err_nxt  = r_frm_err | ~r_rxs;
            // Push straight after the last stop sample so the next start
            // bit can be caught even with zero idle time
            if (r_bit_cnt == STOP_LAST) begin
              w_bit_cnt_nxt = {BIT_W{1'b0}};
              w_push        = 1'b1;
              w_state_nxt   = RX_IDLE;
            end else begin
              w_bit_cnt_nxt = r_bit_cnt + BIT_W'(1);
            end
          end else begin
            w_tick_cnt_nxt = r_tick_cnt + CNT_W'(1);
          end
        end
        default: begin
          w_state_nxt    = RX_IDLE;
          w_tick_cnt_nxt = {CNT_W{1'b0}};
          w_bit_cnt_nxt  = {BIT_W{1'b0}};
        end
      endcase
    end else begin
      w_push = 1'b0;
    end
  end

  // Flags include the sample being taken on the pushing tick
  assign w_push_word = {w_par_err_nxt, w_frm_err_nxt, r_shift};

  // FSM state and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= RX_IDLE;
      r_tick_cnt <= {CNT_W{1'b0}};
      r_bit_cnt  <= {BIT_W{1'b0}};
      r_shift    <= {DATA_BITS{1'b0}};
      r_par_err  <= 1'b0;
      r_frm_err  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_tick_cnt <= w_tick_cnt_nxt;
      r_bit_cnt  <= w_bit_cnt_nxt;
      r_shift    <= w_shift_nxt;
      r_par_err  <= w_par_err_nxt;
      r_frm_err  <= w_frm_err_nxt;
    end
  end

  assign w_pop  = receive_read_en & ~w_empty;
  // A frame is lost only when the FIFO is full and nothing leaves this cycle
  assign w_drop = w_push & w_full & ~w_pop;

  // Sticky overrun; a new drop wins over a simultaneous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overrun <= 1'b0;
    end else if (w_drop) begin
      r_overrun <= 1'b1;
    end else if (clear_errors) begin
      r_overrun <= 1'b0;
    end else begin
      r_overrun <= r_overrun;
    end
  end

  rx_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_rx_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (w_push),
    .push_data (w_push_word),
    .pop       (receive_read_en),
    .head      (w_head),
    .full      (w_full),
    .empty     (w_empty),
    .count     (fifo_count)
  );

  assign rda               = ~w_empty;
  assign receive_read_line = w_head[DATA_BITS-1:0];
  assign framing_err       = w_head[DATA_BITS];
  assign parity_err        = w_head[DATA_BITS+1];
  assign overrun           = r_overrun;

endmodule

// File: tb/tb_receive_os.sv
// tb_receive_os
//   Directed bench for receive_os. Three instances share clk and
//   sample_tick (a tick every second clk, so non-tick cycles are exercised):
//     a: 8N1, depth 4       b: 8 bits even parity      c: 7 bits odd parity, 2 stops
//   One bit period is OVERSAMPLE ticks = 32 clk cycles.
module tb_receive_os;
  localparam int BIT_CLKS = 32;

  logic clk = 1'b0;
  logic sample_tick = 1'b0;
  logic rst_n = 1'b0;
  logic rst_n_c = 1'b0;

  logic rxd_a = 1'b1, re_a = 1'b0, clr_a = 1'b0;
  logic rxd_b = 1'b1, re_b = 1'b0, clr_b = 1'b0;
  logic rxd_c = 1'b1, re_c = 1'b0, clr_c = 1'b0;

  logic       rda_a, fe_a, pe_a, ovr_a;
  logic [7:0] line_a;
  logic [2:0] cnt_a;
  logic       rda_b, fe_b, pe_b, ovr_b;
  logic [7:0] line_b;
  logic [2:0] cnt_b;
  logic       rda_c, fe_c, pe_c, ovr_c;
  logic [6:0] line_c;
  logic [2:0] cnt_c;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;
  always @(negedge clk) sample_tick = ~sample_tick;

  receive_os #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .rxd(rxd_a), .sample_tick(sample_tick),
    .receive_read_en(re_a), .clear_errors(clr_a), .rda(rda_a),
    .receive_read_line(line_a), .framing_err(fe_a), .parity_err(pe_a),
    .overrun(ovr_a), .fifo_count(cnt_a));

  receive_os #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .rxd(rxd_b), .sample_tick(sample_tick),
    .receive_read_en(re_b), .clear_errors(clr_b), .rda(rda_b),
    .receive_read_line(line_b), .framing_err(fe_b), .parity_err(pe_b),
    .overrun(ovr_b), .fifo_count(cnt_b));

  receive_os #(.DATA_BITS(7), .OVERSAMPLE(16), .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(4)) u_dut_c (
    .clk(clk), .rst_n(rst_n_c), .rxd(rxd_c), .sample_tick(sample_tick),
    .receive_read_en(re_c), .clear_errors(clr_c), .rda(rda_c),
    .receive_read_line(line_c), .framing_err(fe_c), .parity_err(pe_c),
    .overrun(ovr_c), .fifo_count(cnt_c));

  // Drive one bit on the selected line for a full bit period
  task automatic drive_bit(input int sel, input logic b);
    case (sel)
      0:       rxd_a = b;
      1:       rxd_b = b;
      default: rxd_c = b;
    endcase
    repeat (BIT_CLKS) @(negedge clk);
  endtask

  // Start bit, data LSB first, optional parity bit, stop bits; line left high
  task automatic send_frame(input int sel, input logic [8:0] data, input int nbits,
                            input bit has_par, input logic par_bit,
                            input int nstop, input logic stop_val);
    drive_bit(sel, 1'b0);
    for (int i = 0; i < nbits; i++) drive_bit(sel, data[i]);
    if (has_par) drive_bit(sel, par_bit);
    for (int i = 0; i < nstop; i++) drive_bit(sel, stop_val);
    case (sel)
      0:       rxd_a = 1'b1;
      1:       rxd_b = 1'b1;
      default: rxd_c = 1'b1;
    endcase
  endtask

  task automatic pop_a();
    re_a = 1'b1; @(negedge clk); re_a = 1'b0;
  endtask

  task automatic pop_b();
    re_b = 1'b1; @(negedge clk); re_b = 1'b0;
  endtask

  task automatic test_reset();
    repeat (4) @(negedge clk);
    rst_n = 1'b1; rst_n_c = 1'b1;
    repeat (4) @(negedge clk);
    checks++; if (rda_a !== 1'b0) begin errors++; $display("FAIL reset_rda got %0b exp 0", rda_a); end
    checks++; if (line_a !== 8'h00) begin errors++; $display("FAIL reset_line got %h exp 00", line_a); end
    checks++; if (fe_a !== 1'b0) begin errors++; $display("FAIL reset_fe got %0b exp 0", fe_a); end
    checks++; if (pe_a !== 1'b0) begin errors++; $display("FAIL reset_pe got %0b exp 0", pe_a); end
    checks++; if (ovr_a !== 1'b0) begin errors++; $display("FAIL reset_ovr got %0b exp 0", ovr_a); end
    checks++; if (cnt_a !== 3'd0) begin errors++; $display("FAIL reset_cnt got %0d exp 0", cnt_a); end
    checks++; if (rda_c !== 1'b0) begin errors++; $display("FAIL reset_rda_c got %0b exp 0", rda_c); end
  endtask

  task automatic test_basic_8n1();
    send_frame(0, 9'h0A5, 8, 1'b0, 1'b0, 1, 1'b1);
    @(negedge clk);
    checks++; if (rda_a !== 1'b1) begin errors++; $display("FAIL basic_rda got %0b exp 1", rda_a); end
    checks++; if (line_a !== 8'hA5) begin errors++; $display("FAIL basic_data got %h exp a5", line_a); end
    checks++; if ({fe_a, pe_a} !== 2'b00) begin errors++; $display("FAIL basic_flags got %b exp 00", {fe_a, pe_a}); end
    checks++; if (cnt_a !== 3'd1) begin errors++; $display("FAIL basic_cnt got %0d exp 1", cnt_a); end
    pop_a();
    checks++; if (rda_a !== 1'b0) begin errors++; $display("FAIL basic_pop_rda got %0b exp 0", rda_a); end
    checks++; if (cnt_a !== 3'd0) begin errors++; $display("FAIL basic_pop_cnt got %0d exp 0", cnt_a); end
  endtask

  task automatic test_parity_even();
    // 0x03 has an even number of ones, so the correct even-parity bit is 0
    send_frame(1, 9'h003, 8, 1'b1, 1'b1, 1, 1'b1);
    @(negedge clk);
    checks++; if (pe_b !== 1'b1) begin errors++; $display("FAIL par_bad_pe got %0b exp 1", pe_b); end
    checks++; if (line_b !== 8'h03) begin errors++; $display("FAIL par_bad_data got %h exp 03", line_b); end
    checks++; if (fe_b !== 1'b0) begin errors++; $display("FAIL par_bad_fe got %0b exp 0", fe_b); end
    pop_b();
    send_frame(1, 9'h003, 8, 1'b1, 1'b0, 1, 1'b1);
    @(negedge clk);
    checks++; if (pe_b !== 1'b0) begin errors++; $display("FAIL par_ok_pe got %0b exp 0", pe_b); end
    checks++; if (line_b !== 8'h03) begin errors++; $display("FAIL par_ok_data got %h exp 03", line_b); end
    pop_b();
    checks++; if (rda_b !== 1'b0) begin errors++; $display("FAIL par_pop_rda got %0b exp 0", rda_b); end
  endtask

  task automatic test_framing_back_to_back();
    send_frame(0, 9'h03C, 8, 1'b0, 1'b0, 1, 1'b0);
    send_frame(0, 9'h055, 8, 1'b0, 1'b0, 1, 1'b1);
    @(negedge clk);
    checks++; if (cnt_a !== 3'd2) begin errors++; $display("FAIL b2b_cnt got %0d exp 2", cnt_a); end
    checks++; if (line_a !== 8'h3C) begin errors++; $display("FAIL frm_data got %h exp 3c", line_a); end
    checks++; if (fe_a !== 1'b1) begin errors++; $display("FAIL frm_fe got %0b exp 1", fe_a); end
    pop_a();
    checks++; if (line_a !== 8'h55) begin errors++; $display("FAIL b2b_data got %h exp 55", line_a); end
    checks++; if ({fe_a, pe_a} !== 2'b00) begin errors++; $display("FAIL b2b_flags got %b exp 00", {fe_a, pe_a}); end
    pop_a();
  endtask

  task automatic test_glitch();
    rxd_a = 1'b0;
    repeat (8) @(negedge clk);
    rxd_a = 1'b1;
    repeat (2 * BIT_CLKS) @(negedge clk);
    checks++; if (rda_a !== 1'b0) begin errors++; $display("FAIL glitch_rda got %0b exp 0", rda_a); end
    send_frame(0, 9'h081, 8, 1'b0, 1'b0, 1, 1'b1);
    @(negedge clk);
    checks++; if (line_a !== 8'h81) begin errors++; $display("FAIL glitch_next_data got %h exp 81", line_a); end
    checks++; if (cnt_a !== 3'd1) begin errors++; $display("FAIL glitch_next_cnt got %0d exp 1", cnt_a); end
    pop_a();
  endtask

  task automatic test_overrun();
    for (int i = 1; i <= 5; i++) begin
      send_frame(0, 9'(i), 8, 1'b0, 1'b0, 1, 1'b1);
    end
    @(negedge clk);
    checks++; if (ovr_a !== 1'b1) begin errors++; $display("FAIL ovr_set got %0b exp 1", ovr_a); end
    checks++; if (cnt_a !== 3'd4) begin errors++; $display("FAIL ovr_cnt got %0d exp 4", cnt_a); end
    for (int i = 1; i <= 4; i++) begin
      checks++;
      if (line_a !== 8'(i)) begin errors++; $display("FAIL ovr_read%0d got %h exp %h", i, line_a, 8'(i)); end
      pop_a();
    end
    checks++; if (rda_a !== 1'b0) begin errors++; $display("FAIL ovr_empty_rda got %0b exp 0", rda_a); end
    // Popping an empty FIFO must be ignored
    pop_a();
    checks++; if (cnt_a !== 3'd0) begin errors++; $display("FAIL empty_pop_cnt got %0d exp 0", cnt_a); end
    checks++; if (ovr_a !== 1'b1) begin errors++; $display("FAIL ovr_sticky got %0b exp 1", ovr_a); end
    clr_a = 1'b1; @(negedge clk); clr_a = 1'b0;
    checks++; if (ovr_a !== 1'b0) begin errors++; $display("FAIL ovr_clear got %0b exp 0", ovr_a); end
  endtask

  task automatic test_reset_mid_frame();
    // 0x7F: seven ones, odd-parity bit 0
    send_frame(2, 9'h07F, 7, 1'b1, 1'b0, 2, 1'b1);
    @(negedge clk);
    checks++; if (line_c !== 7'h7F) begin errors++; $display("FAIL c_data got %h exp 7f", line_c); end
    checks++; if ({fe_c, pe_c} !== 2'b00) begin errors++; $display("FAIL c_flags got %b exp 00", {fe_c, pe_c}); end
    drive_bit(2, 1'b0);
    drive_bit(2, 1'b1);
    drive_bit(2, 1'b0);
    rst_n_c = 1'b0;
    rxd_c = 1'b1;
    @(negedge clk);
    checks++; if (rda_c !== 1'b0) begin errors++; $display("FAIL rst_mid_rda got %0b exp 0", rda_c); end
    checks++; if (cnt_c !== 3'd0) begin errors++; $display("FAIL rst_mid_cnt got %0d exp 0", cnt_c); end
    checks++; if (line_c !== 7'h00) begin errors++; $display("FAIL rst_mid_line got %h exp 00", line_c); end
    checks++; if ({ovr_c, fe_c, pe_c} !== 3'b000) begin errors++; $display("FAIL rst_mid_flags got %b exp 000", {ovr_c, fe_c, pe_c}); end
    repeat (2) @(negedge clk);
    rst_n_c = 1'b1;
    repeat (BIT_CLKS) @(negedge clk);
    checks++; if (rda_c !== 1'b0) begin errors++; $display("FAIL rst_idle_rda got %0b exp 0", rda_c); end
    // 0x2A: three ones, odd-parity bit 0
    send_frame(2, 9'h02A, 7, 1'b1, 1'b0, 2, 1'b1);
    @(negedge clk);
    checks++; if (line_c !== 7'h2A) begin errors++; $display("FAIL c_after_rst_data got %h exp 2a", line_c); end
    checks++; if ({fe_c, pe_c} !== 2'b00) begin errors++; $display("FAIL c_after_rst_flags got %b exp 00", {fe_c, pe_c}); end
    checks++; if (cnt_c !== 3'd1) begin errors++; $display("FAIL c_after_rst_cnt got %0d exp 1", cnt_c); end
    // Same word with the wrong parity bit, and second stop bit low
    drive_bit(2, 1'b0);
    for (int i = 0; i < 7; i++) begin
      drive_bit(2, (i % 2) == 1);
    end
    drive_bit(2, 1'b1);
    drive_bit(2, 1'b1);
    drive_bit(2, 1'b0);
    rxd_c = 1'b1;
    @(negedge clk);
    checks++; if (cnt_c !== 3'd2) begin errors++; $display("FAIL c_err_cnt got %0d exp 2", cnt_c); end
    re_c = 1'b1; @(negedge clk); re_c = 1'b0;
    checks++; if (line_c !== 7'h2A) begin errors++; $display("FAIL c_err_data got %h exp 2a", line_c); end
    checks++; if ({fe_c, pe_c} !== 2'b11) begin errors++; $display("FAIL c_err_flags got %b exp 11", {fe_c, pe_c}); end
  endtask

  initial begin
    test_reset();
    test_basic_8n1();
    test_parity_even();
    test_framing_back_to_back();
    test_glitch();
    test_overrun();
    test_reset_mid_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
